sort_ctrl: RTL and testbench

Sequential sorting controller that shares a single magnitude-comparator datapath across a small register bank. It accepts a burst of DEPTH unsigned W-bit values over a valid/ready input and sorts them in place with one compare-and-swap per cycle (bubble sort with early exit). It then streams the values out in ascending order over a valid/ready output. It sits between a producer of unordered samples and a consumer that needs them ranked.

---
 rtl/sort_pkg.sv | 26 ++
 rtl/cmp_unit.sv | 19 +
 rtl/sort_ctrl.sv | 143 ++++++++++++++
 tb/tb_sort_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and helpers for the sorting controller.
package sort_pkg;

    // Controller phases: fill the bank, sort in place, stream out.
    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

    // Width of the per-burst swap counter.
    localparam int unsigned SWAP_W = 8;

    // Ceiling log2, minimum 1 bit wide for any value >= 2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cmp_unit.sv
// Unsigned W-bit magnitude comparator shared by all compare-and-swap steps.
module cmp_unit #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    // Exactly one of lt/eq/gt is high for any pair of operands.
    always_comb begin
        lt = (a < b);
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/sort_ctrl.sv
// Burst sorting controller: loads DEPTH values, bubble-sorts them in place
// with one compare-and-swap per cycle (early exit on a swap-free pass),
// then streams them out smallest first.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic              busy,
    output logic [SWAP_W-1:0] swap_count
);

    localparam int unsigned       PTR_W    = clog2(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(DEPTH - 2);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [SWAP_W-1:0] SWAP_ONE = SWAP_W'(1);

    state_t           state;
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] idx_n;
    logic [PTR_W-1:0] pass;
    logic             swapped;
    logic [W-1:0]     cmp_a;
    logic [W-1:0]     cmp_b;
    logic             cmp_lt;
    logic             cmp_eq;
    logic             cmp_gt;

    // Select the adjacent pair under comparison.
    always_comb begin
        idx_n = idx + PTR_ONE;
        cmp_a = mem[idx];
        cmp_b = mem[idx_n];
    end

    cmp_unit #(
        .W (W)
    ) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    // Handshake/status flags decoded from the registered state; data from the bank.
    always_comb begin
        in_ready  = (state == LOAD);
        busy      = (state == SORT);
        out_valid = (state == DRAIN);
        out_data  = mem[rd_ptr];
    end

    // Controller: load, compare-and-swap sweep, drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            idx        <= '0;
            pass       <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        mem[wr_ptr] <= in_data;
                        if (wr_ptr == LAST_PTR) begin
                            wr_ptr     <= '0;
                            idx        <= '0;
                            pass       <= '0;
                            swapped    <= 1'b0;
                            swap_count <= '0;
                            state      <= SORT;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end
                    end
                end
                SORT: begin
                    // Strictly-greater only, so equal values keep their order.
                    if (cmp_gt) begin
                        mem[idx]   <= cmp_b;
                        mem[idx_n] <= cmp_a;
                        swap_count <= swap_count + SWAP_ONE;
                    end
                    if (idx == LAST_IDX) begin
                        // This cycle's swap counts toward the early-exit decision.
                        if (!(swapped || cmp_gt) || (pass == LAST_IDX)) begin
                            rd_ptr <= '0;
                            state  <= DRAIN;
                        end else begin
                            pass    <= pass + PTR_ONE;
                            idx     <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        idx <= idx_n;
                        if (cmp_gt) begin
                            swapped <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr == LAST_PTR) begin
                            rd_ptr <= '0;
                            wr_ptr <= '0;
                            state  <= LOAD;
                        end else begin
                            rd_ptr <= rd_ptr + PTR_ONE;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // The comparator must always report exactly one relation.
    a_cmp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({cmp_lt, cmp_eq, cmp_gt}));

endmodule

// File: tb/tb_sort_ctrl.sv
// Bench for sort_ctrl: directed bursts, resets in every phase, random bursts.
module tb_sort_ctrl;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic [7:0]   swap_count;

    int checks = 0;
    int errors = 0;

    sort_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .swap_count (swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase: 0 load, 1 sort, 2 drain.
    int m_phase = 0;
    int m_n = 0;
    int m_rd = 0;
    int m_left = 0;
    int m_len = 0;
    int m_swap_exp = 0;
    int m_vals [DEPTH];
    int m_exp  [DEPTH];

    // Sorted order, inversion count, and bubble-sort length from the burst contents.
    function automatic void model_burst();
        int inv, maxk, k, passes, tmp;
        inv = 0;
        maxk = 0;
        for (int j = 0; j < DEPTH; j++) begin
            k = 0;
            for (int i = 0; i < j; i++) if (m_vals[i] > m_vals[j]) k++;
            inv += k;
            if (k > maxk) maxk = k;
        end
        for (int i = 0; i < DEPTH; i++) m_exp[i] = m_vals[i];
        for (int i = 1; i < DEPTH; i++) begin
            for (int j = i; j > 0 && m_exp[j-1] > m_exp[j]; j--) begin
                tmp = m_exp[j]; m_exp[j] = m_exp[j-1]; m_exp[j-1] = tmp;
            end
        end
        // An element with k larger predecessors needs k passes; one more swap-free pass confirms.
        if (maxk == 0) passes = 1;
        else passes = (maxk + 1 < DEPTH - 1) ? maxk + 1 : DEPTH - 1;
        m_left = passes * (DEPTH - 1);
        m_len = m_left;
        m_swap_exp = inv;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_n = 0; m_rd = 0; m_left = 0; m_swap_exp = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_vals[m_n] = int'(in_data);
                    m_n++;
                    if (m_n == DEPTH) begin
                        model_burst();
                        m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 2; m_rd = 0; end
                end
                default: if (out_ready) begin
                    m_rd++;
                    if (m_rd == DEPTH) begin m_phase = 0; m_n = 0; m_rd = 0; end
                end
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("in_ready", in_ready, m_phase == 0);
        chk("busy", busy, m_phase == 1);
        chk("out_valid", out_valid, m_phase == 2);
        if (m_phase == 2) chk("out_data", out_data, m_exp[m_rd]);
        if (m_phase != 1) chk("swap_count", swap_count, m_swap_exp);
    end

    // ---------------- stimulus ----------------
    int dv [DEPTH];
    int de [DEPTH];
    int got [DEPTH];

    // Called at a negedge; returns at the negedge after the value is accepted.
    task automatic send_val(input int v, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data = v[W-1:0];
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_sorted(output int bc);
        int t;
        bc = 0;
        t = 0;
        while (!out_valid && t < 100) begin
            if (busy) bc++;
            @(negedge clk);
            t++;
        end
        chk("sort_done", out_valid, 1);
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random.
    task automatic recv_burst(input int mode);
        int n, c;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        n = 0;
        c = 0;
        while (n < DEPTH && c < 500) begin
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = pat[c % 4];
            else out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                got[n] = int'(out_data);
                n++;
            end
            @(negedge clk);
            c++;
        end
        out_ready = 1'b0;
        chk("drain_done", n, DEPTH);
    endtask

    task automatic run_dir(input string tag, input int mode, input int exp_sw, input int exp_busy);
        int bc;
        for (int i = 0; i < DEPTH; i++) send_val(dv[i], 0);
        wait_sorted(bc);
        chk({tag, "_busy_cycles"}, bc, exp_busy);
        chk({tag, "_model_len"}, m_len, exp_busy);
        chk({tag, "_swap_count"}, swap_count, exp_sw);
        chk({tag, "_model_swaps"}, m_swap_exp, exp_sw);
        recv_burst(mode);
        for (int i = 0; i < DEPTH; i++) chk({tag, "_out"}, got[i], de[i]);
        chk({tag, "_in_ready_after"}, in_ready, 1);
        chk({tag, "_out_valid_after"}, out_valid, 0);
    endtask

    // Called at a negedge; asserts reset away from the clock edge and checks reset values.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_rst_in_ready"}, in_ready, 1);
        chk({tag, "_rst_out_valid"}, out_valid, 0);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_swap_count"}, swap_count, 0);
        chk({tag, "_rst_out_data"}, out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_swap_count", swap_count, 0);
        chk("reset_out_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        dv = '{1, 2, 3, 4};    de = '{1, 2, 3, 4};    run_dir("sorted", 0, 0, 3);
        dv = '{11, 10, 0, 15}; de = '{0, 10, 11, 15}; run_dir("mixed", 0, 3, 9);
        dv = '{15, 10, 5, 0};  de = '{0, 5, 10, 15};  run_dir("reverse", 0, 6, 9);
        dv = '{7, 7, 3, 7};    de = '{3, 7, 7, 7};    run_dir("stall", 1, 2, 9);

        // Reset mid-LOAD.
        send_val(9, 0);
        send_val(2, 0);
        reset_pulse("load");
        // Reset mid-SORT.
        dv = '{15, 10, 5, 0};
        for (int i = 0; i < DEPTH; i++) send_val(dv[i], 0);
        @(negedge clk);
        @(negedge clk);
        chk("sort_busy_before_reset", busy, 1);
        reset_pulse("sort");
        // Reset mid-DRAIN.
        dv = '{3, 1, 2, 0};
        for (int i = 0; i < DEPTH; i++) send_val(dv[i], 0);
        wait_sorted(bc);
        chk("drain_swaps_before_reset", swap_count, 5);
        reset_pulse("drain");

        dv = '{4, 3, 2, 1};    de = '{1, 2, 3, 4};    run_dir("fresh", 0, 6, 9);

        for (int b = 0; b < 200; b++) begin
            for (int i = 0; i < DEPTH; i++) send_val(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            wait_sorted(bc);
            chk("rand_busy_cycles", bc, m_len);
            recv_burst(2);
            for (int i = 0; i < DEPTH; i++) chk("rand_out", got[i], m_exp[i]);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
